dac_write_scheduler: RTL and testbench

// Shares the single SPI DAC writer between NUM_REQ setpoint sources (PID output, sweep generator, manual).

---
 rtl/dac_pkg.sv | 20 ++
 rtl/dac_write_scheduler_rr_arbiter.sv | 27 ++
 rtl/dac_write_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dac_write_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and helpers for the DAC write scheduler.
package dac_pkg;

  localparam int DAC_W   = 16;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_GAP   = 2'd3
  } sched_state_t;

  // Extract requester idx from a flat bus zero-padded to MAX_REQ slots.
  function automatic logic [DAC_W-1:0] req_slice(input logic [MAX_REQ*DAC_W-1:0] bus,
                                                 input int idx);
    return bus[idx*DAC_W +: DAC_W];
  endfunction

endpackage

// File: rtl/dac_write_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan offsets from the far end so the offset closest to ptr_i wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = |req_i;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        grant_o = '0;
        grant_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/dac_write_scheduler.sv
// Latest-value-wins mailbox per setpoint source, round-robin access to one SPI DAC writer,
// with a minimum idle gap between frames.
module dac_write_scheduler
  import dac_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MIN_GAP = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*DAC_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       pending_o,
  output logic [NUM_REQ-1:0]       overwrite_o,
  output logic signed [DAC_W-1:0]  dac_data_o,
  output logic                     dac_start_o,
  input  logic                     dac_idle_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [2:0]               done_src_o,
  output logic signed [DAC_W-1:0]  last_value_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;

  sched_state_t state_q, state_d;

  logic [DAC_W-1:0]         data_q [NUM_REQ];
  logic [DAC_W-1:0]         data_d [NUM_REQ];
  logic [NUM_REQ-1:0]       pend_q, pend_d, ovw_q, ovw_d;
  logic [NUM_REQ-1:0]       grant_s, take_mask_s;
  logic [IDX_W-1:0]         rr_q, rr_d, gidx_s;
  logic                     any_s, take_s;
  logic [DAC_W-1:0]         dac_data_q, dac_data_d, last_q, last_d;
  logic                     start_q, start_d, busy_q, busy_d, done_q, done_d;
  logic [2:0]               src_q, src_d, done_src_q, done_src_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [MAX_REQ*DAC_W-1:0] req_bus_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (pend_q),
    .ptr_i   (rr_q),
    .grant_o (grant_s),
    .idx_o   (gidx_s),
    .any_o   (any_s)
  );

  // Mailboxes: a post on the grant edge survives as a new pending value.
  always_comb begin
    req_bus_s = '0;
    req_bus_s[NUM_REQ*DAC_W-1:0] = req_data_i;
    take_s      = (state_q == S_IDLE) && any_s && dac_idle_i;
    take_mask_s = take_s ? grant_s : '0;
    pend_d      = (pend_q & ~take_mask_s) | req_valid_i;
    ovw_d       = req_valid_i & pend_q & ~take_mask_s;
    for (int i = 0; i < NUM_REQ; i++) begin
      data_d[i] = req_valid_i[i] ? req_slice(req_bus_s, i) : data_q[i];
    end
  end

  // Frame sequencing and gap timing; S_GAP lasts exactly MIN_GAP cycles.
  always_comb begin
    state_d    = state_q;
    dac_data_d = dac_data_q;
    rr_d       = rr_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    done_src_d = done_src_q;
    last_d     = last_q;
    case (state_q)
      S_IDLE: begin
        if (take_s) begin
          state_d    = S_START;
          dac_data_d = data_q[gidx_s];
          src_d      = 3'(gidx_s);
          rr_d       = (gidx_s == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_s + IDX_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!dac_idle_i) state_d = S_BUSY;
        else             state_d = S_START;
      end
      S_BUSY: begin
        if (dac_idle_i) begin
          done_d     = 1'b1;
          done_src_d = src_q;
          last_d     = dac_data_q;
          if (MIN_GAP == 0) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_GAP;
            cnt_d   = CNT_W'(MIN_GAP);
          end
        end else begin
          state_d = S_BUSY;
        end
      end
      S_GAP: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    start_d = (state_d == S_START);
    busy_d  = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      ovw_q      <= '0;
      rr_q       <= '0;
      src_q      <= 3'd0;
      cnt_q      <= '0;
      dac_data_q <= '0;
      last_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      done_src_q <= 3'd0;
      for (int i = 0; i < NUM_REQ; i++) data_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      ovw_q      <= ovw_d;
      rr_q       <= rr_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      dac_data_q <= dac_data_d;
      last_q     <= last_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      done_src_q <= done_src_d;
      for (int i = 0; i < NUM_REQ; i++) data_q[i] <= data_d[i];
    end
  end

  assign pending_o    = pend_q;
  assign overwrite_o  = ovw_q;
  assign dac_data_o   = dac_data_q;
  assign dac_start_o  = start_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign done_src_o   = done_src_q;
  assign last_value_o = last_q;

endmodule

// File: tb/tb_dac_write_scheduler.sv
// Directed bench: two schedulers (MIN_GAP 8 and 0), each with a behavioural DAC writer
// that records frames in offset-binary as the SPI word would carry them.
module tb_dac_write_scheduler;

  localparam int N        = 4;
  localparam int BUSY_LEN = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    rv_a, rv_b;
  logic [N*16-1:0] rdata;

  logic [N-1:0] pend_a, ovw_a, pend_b, ovw_b;
  logic [15:0]  data_a, last_a, data_b, last_b;
  logic         start_a, busy_a, done_a, widle_a;
  logic         start_b, busy_b, done_b, widle_b;
  logic [2:0]   dsrc_a, dsrc_b;

  dac_write_scheduler #(.NUM_REQ(N), .MIN_GAP(8)) dut_a (
    .clk_i(clk), .reset_i(rst), .req_valid_i(rv_a), .req_data_i(rdata),
    .pending_o(pend_a), .overwrite_o(ovw_a), .dac_data_o(data_a), .dac_start_o(start_a),
    .dac_idle_i(widle_a), .busy_o(busy_a), .done_o(done_a), .done_src_o(dsrc_a),
    .last_value_o(last_a));

  dac_write_scheduler #(.NUM_REQ(N), .MIN_GAP(0)) dut_b (
    .clk_i(clk), .reset_i(rst), .req_valid_i(rv_b), .req_data_i(rdata),
    .pending_o(pend_b), .overwrite_o(ovw_b), .dac_data_o(data_b), .dac_start_o(start_b),
    .dac_idle_i(widle_b), .busy_o(busy_b), .done_o(done_b), .done_src_o(dsrc_b),
    .last_value_o(last_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Writer models: accept start when idle, stay busy BUSY_LEN+1 cycles.
  int          wcnt_a, wcnt_b;
  logic [15:0] frames_a[$], frames_b[$];
  always @(posedge clk) begin
    if (rst) begin
      widle_a <= 1'b1; wcnt_a <= 0;
    end else if (widle_a && start_a) begin
      widle_a <= 1'b0; wcnt_a <= BUSY_LEN; frames_a.push_back(data_a ^ 16'h8000);
    end else if (!widle_a) begin
      if (wcnt_a == 0) widle_a <= 1'b1;
      else             wcnt_a <= wcnt_a - 1;
    end
  end
  always @(posedge clk) begin
    if (rst) begin
      widle_b <= 1'b1; wcnt_b <= 0;
    end else if (widle_b && start_b) begin
      widle_b <= 1'b0; wcnt_b <= BUSY_LEN; frames_b.push_back(data_b ^ 16'h8000);
    end else if (!widle_b) begin
      if (wcnt_b == 0) widle_b <= 1'b1;
      else             wcnt_b <= wcnt_b - 1;
    end
  end

  // Event monitors sampled mid-cycle.
  int   dsrcs_a[$], dsrcs_b[$], starts_a[$], starts_b[$], rises_a[$], rises_b[$], falls_b[$];
  int   ov_a[N] = '{default: 0};
  int   ov_b = 0;
  logic sp_a = 1'b0, ip_a = 1'b0, sp_b = 1'b0, ip_b = 1'b0, bp_b = 1'b0;
  always @(negedge clk) begin
    if (done_a) dsrcs_a.push_back(int'(dsrc_a));
    if (done_b) dsrcs_b.push_back(int'(dsrc_b));
    for (int i = 0; i < N; i++) if (ovw_a[i]) ov_a[i] <= ov_a[i] + 1;
    if (|ovw_b) ov_b <= ov_b + 1;
    if (start_a && !sp_a) starts_a.push_back(cyc);
    if (start_b && !sp_b) starts_b.push_back(cyc);
    if (widle_a && !ip_a) rises_a.push_back(cyc);
    if (widle_b && !ip_b) rises_b.push_back(cyc);
    if (!busy_b && bp_b) falls_b.push_back(cyc);
    sp_a <= start_a; ip_a <= widle_a; sp_b <= start_b; ip_b <= widle_b; bp_b <= busy_b;
  end

  int errors = 0;
  int checks = 0;

  task automatic clear_logs();
    frames_a.delete(); frames_b.delete(); dsrcs_a.delete(); dsrcs_b.delete();
    starts_a.delete(); starts_b.delete(); rises_a.delete(); rises_b.delete(); falls_b.delete();
  endtask

  task automatic post_a(input int i, input logic [15:0] v);
    rv_a[i] = 1'b1;
    rdata[16*i +: 16] = v;
    @(negedge clk);
    rv_a = '0;
  endtask

  task automatic wait_quiet();
    int k;
    for (k = 0; k < 400; k++) begin
      if (!busy_a && pend_a == '0 && widle_a && !busy_b && pend_b == '0 && widle_b) break;
      @(negedge clk);
    end
    checks++;
    if (k >= 400) begin
      errors++;
      $display("FAIL quiet_timeout: busy_a=%0b pend_a=%b busy_b=%0b, required idle", busy_a, pend_a, busy_b);
    end
  endtask

  task automatic wait_writer_busy();
    int k;
    for (k = 0; k < 50; k++) begin
      if (!widle_a) break;
      @(negedge clk);
    end
    checks++;
    if (k >= 50) begin
      errors++;
      $display("FAIL writer_start_timeout: dac_idle stayed %0b, required 0", widle_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({pend_a, ovw_a, start_a, done_a, busy_a} !== 11'd0) begin
      errors++;
      $display("FAIL reset_flags: pend=%b ovw=%b start=%b done=%b busy=%b, required all 0",
               pend_a, ovw_a, start_a, done_a, busy_a);
    end
    checks++;
    if (data_a !== 16'h0000 || last_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data: dac_data=%h last=%h, required 0000/0000", data_a, last_a);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_post();
    int p;
    clear_logs();
    p = cyc;
    post_a(1, 16'h1234);
    wait_quiet();
    checks++;
    if (starts_a.size() != 1 || starts_a[0] - p != 2) begin
      errors++;
      $display("FAIL single_latency: got %0d starts, latency %0d, required 1 start latency 2",
               starts_a.size(), starts_a[0] - p);
    end
    checks++;
    if (frames_a.size() != 1 || frames_a[0] !== 16'h9234) begin
      errors++;
      $display("FAIL single_frame: got n=%0d first=%h, required n=1 9234", frames_a.size(), frames_a[0]);
    end
    checks++;
    if (dsrcs_a.size() != 1 || dsrcs_a[0] != 1) begin
      errors++;
      $display("FAIL single_done_src: got n=%0d src=%0d, required n=1 src=1", dsrcs_a.size(), dsrcs_a[0]);
    end
    checks++;
    if (last_a !== 16'h1234) begin
      errors++;
      $display("FAIL single_last: got %h, required 1234", last_a);
    end
  endtask

  task automatic test_overwrite();
    int b2, bo;
    clear_logs();
    b2 = ov_a[2];
    bo = ov_a[0] + ov_a[1] + ov_a[3];
    post_a(0, 16'h0AAA);
    wait_writer_busy();
    post_a(2, 16'h0100);
    post_a(2, 16'h0200);
    wait_quiet();
    checks++;
    if (ov_a[2] - b2 != 1 || ov_a[0] + ov_a[1] + ov_a[3] != bo) begin
      errors++;
      $display("FAIL overwrite_pulses: got ovw2=%0d others=%0d, required 1 and 0",
               ov_a[2] - b2, ov_a[0] + ov_a[1] + ov_a[3] - bo);
    end
    checks++;
    if (frames_a.size() != 2 || frames_a[0] !== 16'h8AAA || frames_a[1] !== 16'h8200) begin
      errors++;
      $display("FAIL overwrite_frames: got n=%0d %h %h, required n=2 8AAA 8200",
               frames_a.size(), frames_a[0], frames_a[1]);
    end
    checks++;
    if (dsrcs_a.size() != 2 || dsrcs_a[0] != 0 || dsrcs_a[1] != 2) begin
      errors++;
      $display("FAIL overwrite_srcs: got n=%0d %0d %0d, required 0 2", dsrcs_a.size(), dsrcs_a[0], dsrcs_a[1]);
    end
  endtask

  task automatic test_round_robin();
    int          n;
    int          k;
    int          exp_src[5] = '{0, 1, 2, 3, 0};
    logic [15:0] exp_fr[5]  = '{16'h8000, 16'h9111, 16'hA222, 16'hB333, 16'h8000};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    rv_a  = 4'hF;
    rdata = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
    @(negedge clk);
    rv_a = '0;
    n = 0;
    for (k = 0; k < 600 && n < 5; k++) begin
      @(negedge clk);
      if (done_a) begin
        n++;
        if (n < 5) post_a(0, 16'h0000);
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL rr_timeout: got %0d frames, required 5", n);
    end
    wait_quiet();
    checks++;
    if (dsrcs_a.size() != 5 || frames_a.size() != 5) begin
      errors++;
      $display("FAIL rr_count: got %0d dones %0d frames, required 5/5", dsrcs_a.size(), frames_a.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dsrcs_a[i] != exp_src[i] || frames_a[i] !== exp_fr[i]) begin
          errors++;
          $display("FAIL rr_order[%0d]: got src=%0d frame=%h, required src=%0d frame=%h",
                   i, dsrcs_a[i], frames_a[i], exp_src[i], exp_fr[i]);
        end
      end
    end
  endtask

  task automatic test_gap();
    int bb;
    clear_logs();
    bb = ov_b;
    rv_a = 4'b0110;
    rv_b = 4'b0110;
    rdata[31:16] = 16'h0011;
    rdata[47:32] = 16'h0022;
    @(negedge clk);
    rv_a = '0;
    rv_b = '0;
    wait_quiet();
    checks++;
    if (starts_a.size() != 2 || rises_a.size() < 1 || starts_a[1] - rises_a[0] != 10) begin
      errors++;
      $display("FAIL gap8_spacing: idle-rise to start = %0d, required 10 (8 gap cycles)",
               starts_a[1] - rises_a[0]);
    end
    checks++;
    if (starts_b.size() != 2 || rises_b.size() < 1 || starts_b[1] - rises_b[0] != 2) begin
      errors++;
      $display("FAIL gap0_spacing: idle-rise to start = %0d, required 2", starts_b[1] - rises_b[0]);
    end
    checks++;
    if (falls_b.size() < 1 || starts_b[1] != falls_b[0] + 1) begin
      errors++;
      $display("FAIL gap0_idle_to_start: start %0d idle %0d, required start = idle+1", starts_b[1], falls_b[0]);
    end
    checks++;
    if (dsrcs_b.size() != 2 || dsrcs_b[0] != 1 || dsrcs_b[1] != 2 || frames_b[1] !== 16'h8022) begin
      errors++;
      $display("FAIL gap0_frames: got n=%0d srcs %0d %0d frame1=%h, required 1 2 8022",
               dsrcs_b.size(), dsrcs_b[0], dsrcs_b[1], frames_b[1]);
    end
    checks++;
    if (last_b !== 16'h0022 || ov_b != bb) begin
      errors++;
      $display("FAIL gap0_last: got last=%h ovw=%0d, required 0022 and 0", last_b, ov_b - bb);
    end
  endtask

  task automatic test_collision();
    int b3;
    clear_logs();
    b3 = ov_a[3];
    rv_a[3] = 1'b1;
    rdata[63:48] = 16'h8000;
    @(negedge clk);
    rdata[63:48] = 16'h7FFF;
    @(negedge clk);
    rv_a = '0;
    wait_quiet();
    checks++;
    if (frames_a.size() != 2 || frames_a[0] !== 16'h0000 || frames_a[1] !== 16'hFFFF) begin
      errors++;
      $display("FAIL collide_frames: got n=%0d %h %h, required 0000 FFFF", frames_a.size(), frames_a[0], frames_a[1]);
    end
    checks++;
    if (ov_a[3] != b3) begin
      errors++;
      $display("FAIL collide_overwrite: got %0d pulses, required 0", ov_a[3] - b3);
    end
    checks++;
    if (last_a !== 16'h7FFF || dsrcs_a.size() != 2) begin
      errors++;
      $display("FAIL collide_last: got last=%h dones=%0d, required 7FFF 2", last_a, dsrcs_a.size());
    end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    post_a(0, 16'h4321);
    wait_writer_busy();
    repeat (2) @(negedge clk);
    post_a(1, 16'h5555);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (start_a !== 1'b0 || pend_a !== 4'b0000 || last_a !== 16'h0000 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: start=%b pend=%b last=%h busy=%b, required 0 0000 0000 0",
               start_a, pend_a, last_a, busy_a);
    end
    checks++;
    if (widle_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL midreset_writer: idle(cs)=%b done=%b, required 1 0", widle_a, done_a);
    end
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (dsrcs_a.size() != 0 || frames_a.size() != 1 || pend_a !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_after: dones=%0d frames=%0d pend=%b, required 0 1 0000",
               dsrcs_a.size(), frames_a.size(), pend_a);
    end
  endtask

  initial begin
    rst   = 1'b1;
    rv_a  = '0;
    rv_b  = '0;
    rdata = '0;
    @(negedge clk);
    test_reset();
    test_single_post();
    test_overwrite();
    test_round_robin();
    test_gap();
    test_collision();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
